// File: rtl/scanline_buffer.sv
// Double-banked scanline buffer: fills the next display line from a pixel stream
// while the current line is read out with a two-stage pipeline.
module scanline_buffer (
    input  logic       clk_12_5875,
    input  logic       rst,
    input  logic [9:0] hcounter_i,
    input  logic [9:0] vcounter_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       visible_i,
    output logic [8:0] fill_line_o,
    input  logic       fill_valid_i,
    input  logic [5:0] fill_color_i,
    output logic       fill_ready_o,
    output logic [1:0] r_o,
    output logic [1:0] g_o,
    output logic [1:0] b_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       underrun_o
);
    localparam int unsigned LINE_W  = 320;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned COL_W   = 6;
    localparam int unsigned V_LAST  = 524;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic {ST_IDLE, ST_FILL} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [1:0]          bank_valid_q;
    logic [COL_W-1:0]    bank0_q [LINE_W];
    logic [COL_W-1:0]    bank1_q [LINE_W];

    logic [ADDR_W-1:0]   rd_addr_q;
    logic                rd_bank_q;
    logic                gate_q;
    logic                hsync_q;
    logic                vsync_q;

    logic [9:0]          fill_target;
    logic                fill_start;
    logic                beat_accept;
    logic [COL_W-1:0]    rd_pixel;
    logic [COL_W-1:0]    pix_d;

    assign fill_target = (vcounter_i == 10'(V_LAST)) ? 10'd0 : vcounter_i + 10'd1;
    assign fill_start  = (hcounter_i == 10'd0) && (fill_target < 10'(V_ACTIVE));
    assign beat_accept = fill_valid_i && fill_ready_o;

    // Fill FSM; a new line start always wins over a pending beat and flags an unfinished fill.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fill_ready_o <= 1'b0;
            fill_line_o  <= '0;
            waddr_q      <= '0;
            bank_valid_q <= '0;
            underrun_o   <= 1'b0;
        end else if (fill_start) begin
            if (state_q == ST_FILL) begin
                underrun_o <= 1'b1;
            end
            state_q                     <= ST_FILL;
            fill_ready_o                <= 1'b1;
            fill_line_o                 <= fill_target[8:0];
            waddr_q                     <= '0;
            bank_valid_q[fill_target[0]] <= 1'b0;
        end else if (beat_accept) begin
            if (waddr_q == ADDR_W'(LINE_W - 1)) begin
                state_q                     <= ST_IDLE;
                fill_ready_o                <= 1'b0;
                bank_valid_q[fill_line_o[0]] <= 1'b1;
            end else begin
                waddr_q <= waddr_q + ADDR_W'(1);
            end
        end
    end

    // Line RAM write port; contents are never reset, bank_valid gates reads instead.
    always_ff @(posedge clk_12_5875) begin
        if (beat_accept && !fill_start) begin
            if (fill_line_o[0]) begin
                bank1_q[waddr_q] <= fill_color_i;
            end else begin
                bank0_q[waddr_q] <= fill_color_i;
            end
        end
    end

    assign rd_pixel = rd_bank_q ? bank1_q[rd_addr_q] : bank0_q[rd_addr_q];
    assign pix_d    = gate_q ? rd_pixel : '0;

    // Display pipeline: stage 1 captures address/gate, stage 2 captures pixel data.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            rd_addr_q <= '0;
            rd_bank_q <= 1'b0;
            gate_q    <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            r_o       <= '0;
            g_o       <= '0;
            b_o       <= '0;
            hsync_o   <= 1'b1;
            vsync_o   <= 1'b1;
        end else begin
            rd_addr_q <= hcounter_i[8:0];
            rd_bank_q <= vcounter_i[0];
            gate_q    <= visible_i && bank_valid_q[vcounter_i[0]];
            hsync_q   <= hsync_i;
            vsync_q   <= vsync_i;
            r_o       <= pix_d[5:4];
            g_o       <= pix_d[3:2];
            b_o       <= pix_d[1:0];
            hsync_o   <= hsync_q;
            vsync_o   <= vsync_q;
        end
    end
endmodule

// File: tb/tb_scanline_buffer.sv
// Directed bench for scanline_buffer: drives raster lines and a pixel source,
// checks display, fill handshake, underrun and sync delay against a small model.
`timescale 1ns/1ps
module tb_scanline_buffer;
    localparam int unsigned HT = 400;

    logic       clk_12_5875 = 1'b0;
    logic       rst;
    logic [9:0] hcnt, vcnt;
    logic       hs_i, vs_i, vis;
    logic [8:0] fill_line;
    logic       fv;
    logic [5:0] fcol;
    logic       frdy;
    logic [1:0] r, g, b;
    logic       hs_o, vs_o, und;

    always #5 clk_12_5875 = ~clk_12_5875;

    scanline_buffer dut (
        .clk_12_5875 (clk_12_5875),
        .rst         (rst),
        .hcounter_i  (hcnt),
        .vcounter_i  (vcnt),
        .hsync_i     (hs_i),
        .vsync_i     (vs_i),
        .visible_i   (vis),
        .fill_line_o (fill_line),
        .fill_valid_i(fv),
        .fill_color_i(fcol),
        .fill_ready_o(frdy),
        .r_o         (r),
        .g_o         (g),
        .b_o         (b),
        .hsync_o     (hs_o),
        .vsync_o     (vs_o),
        .underrun_o  (und)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_valid [2];
    logic [5:0] m_bank  [2][320];
    bit         m_fill;
    int         m_addr, m_line;
    bit         m_under;
    int         src_cnt, src_beats, src_off;
    int         p_col, p_h;
    bit         p_hs, p_vs;

    int e_pix, e_sync, e_rdy, e_line, e_und;
    int obs_pix [HT];
    int obs_rdy [HT];
    int obs_line[HT];
    int obs_und [HT];

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_fill  = 1'b0;
        m_addr  = 0;
        m_line  = 0;
        m_under = 1'b0;
        src_cnt = 0;
        p_col   = 0;
        p_hs    = 1'b1;
        p_vs    = 1'b1;
        p_h     = HT;
    endtask

    task automatic step(input int h, input int v, input bit hs, input bit vs);
        int tgt;
        bit start, vis_n, acc;
        int e_col;
        vis_n = (h < 320) && (v < 480);
        tgt   = (v == 524) ? 0 : v + 1;
        start = (h == 0) && (tgt < 480);
        hcnt  = 10'(h);
        vcnt  = 10'(v);
        hs_i  = hs;
        vs_i  = vs;
        vis   = vis_n;
        fv    = (src_cnt < src_beats);
        fcol  = 6'(src_cnt + src_off);
        e_col = (vis_n && m_valid[v % 2]) ? int'(m_bank[v % 2][h]) : 0;
        acc   = m_fill && fv;
        if (start) begin
            if (m_fill) m_under = 1'b1;
            m_fill  = 1'b1;
            m_addr  = 0;
            m_line  = tgt;
            m_valid[tgt % 2] = 1'b0;
            src_cnt = 0;
        end else if (acc) begin
            m_bank[m_line % 2][m_addr] = fcol;
            src_cnt++;
            if (m_addr == 319) begin
                m_fill = 1'b0;
                m_valid[m_line % 2] = 1'b1;
            end else begin
                m_addr++;
            end
        end
        @(posedge clk_12_5875);
        #1;
        if (int'({r, g, b}) != p_col) e_pix++;
        if (hs_o != p_hs || vs_o != p_vs) e_sync++;
        if (frdy != m_fill) e_rdy++;
        if (int'(fill_line) != m_line) e_line++;
        if (und != m_under) e_und++;
        if (p_h < 320) obs_pix[p_h] = int'({r, g, b});
        obs_rdy[h]  = int'(frdy);
        obs_line[h] = int'(fill_line);
        obs_und[h]  = int'(und);
        p_col = e_col;
        p_hs  = hs;
        p_vs  = vs;
        p_h   = h;
    endtask

    task automatic clear_line_stats();
        e_pix = 0; e_sync = 0; e_rdy = 0; e_line = 0; e_und = 0;
        for (int i = 0; i < HT; i++) begin
            obs_pix[i] = -1; obs_rdy[i] = -1; obs_line[i] = -1; obs_und[i] = -1;
        end
    endtask

    task automatic run_line(input int v, input int beats, input int off, input int hmax);
        clear_line_stats();
        src_beats = beats;
        src_off   = off;
        for (int h = 0; h < hmax; h++) begin
            step(h, v, !(h >= 330 && h < 350), !(v == 490 || v == 491));
        end
        check_val($sformatf("v%0d pixels", v), e_pix, 0);
        check_val($sformatf("v%0d syncs", v), e_sync, 0);
        check_val($sformatf("v%0d fill_ready", v), e_rdy, 0);
        check_val($sformatf("v%0d fill_line", v), e_line, 0);
        check_val($sformatf("v%0d underrun", v), e_und, 0);
    endtask

    task automatic do_reset(input string tag, input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_12_5875);
            #1;
        end
        model_reset();
        check_val({tag, " fill_ready"}, int'(frdy), 0);
        check_val({tag, " fill_line"}, int'(fill_line), 0);
        check_val({tag, " underrun"}, int'(und), 0);
        check_val({tag, " rgb"}, int'({r, g, b}), 0);
        check_val({tag, " hsync_o"}, int'(hs_o), 1);
        check_val({tag, " vsync_o"}, int'(vs_o), 1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hcnt = '0; vcnt = '0; hs_i = 1'b1; vs_i = 1'b1; vis = 1'b0;
        fv = 1'b0; fcol = '0;
        src_beats = 0; src_off = 0;
        model_reset();

        do_reset("reset", 3);

        // line 0: bank 0 never filled, so black; fill of line 1 starts
        run_line(0, 320, 7, HT);
        check_val("v0 fill_line at h0", obs_line[0], 1);
        check_val("v0 pixel 5 black", obs_pix[5], 0);

        run_line(1, 320, 0, HT);
        check_val("v1 pixel 0", obs_pix[0], 7);
        check_val("v1 pixel 60", obs_pix[60], 3);

        // full-rate fill of line 6 takes exactly 320 cycles
        run_line(5, 320, 0, HT);
        check_val("v5 fill_line", obs_line[0], 6);
        check_val("v5 ready after start", obs_rdy[0], 1);
        check_val("v5 ready at beat 319", obs_rdy[319], 1);
        check_val("v5 ready after beat 320", obs_rdy[320], 0);

        run_line(6, 320, 0, HT);
        check_val("v6 pixel 0", obs_pix[0], 0);
        check_val("v6 pixel 63", obs_pix[63], 63);
        check_val("v6 pixel 64", obs_pix[64], 0);
        check_val("v6 pixel 100", obs_pix[100], 36);
        check_val("v6 pixel 319", obs_pix[319], 63);

        // source stalls after 100 beats for line 10
        run_line(9, 100, 0, HT);
        check_val("v9 underrun still 0", obs_und[399], 0);
        run_line(10, 320, 0, HT);
        check_val("v10 underrun", obs_und[0], 1);
        check_val("v10 restart line", obs_line[0], 11);
        check_val("v10 pixel 5 black", obs_pix[5], 0);
        check_val("v10 pixel 200 black", obs_pix[200], 0);
        run_line(11, 320, 0, HT);
        check_val("v11 underrun sticky", obs_und[399], 1);

        // vertical boundaries
        run_line(478, 320, 0, HT);
        check_val("v478 fill_line", obs_line[0], 479);
        run_line(479, 320, 0, HT);
        check_val("v479 no fill line", obs_line[0], 479);
        check_val("v479 no fill ready", obs_rdy[0], 0);
        run_line(524, 320, 3, HT);
        check_val("v524 fill_line", obs_line[0], 0);
        run_line(0, 320, 0, HT);
        check_val("v0 wrap pixel 10", obs_pix[10], 13);

        // arbitrary sync toggling outside any fill start
        clear_line_stats();
        for (int i = 0; i < 60; i++) begin
            step(350 + (i % 50), 490, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_val("random syncs", e_sync, 0);
        check_val("random syncs pixels", e_pix, 0);

        // reset in the middle of a fill, after 150 beats
        run_line(20, 320, 0, 151);
        check_val("v20 ready mid-fill", obs_rdy[150], 1);
        do_reset("mid-fill reset", 1);
        run_line(0, 320, 0, HT);
        check_val("post-reset v0 pixel 10 black", obs_pix[10], 0);
        check_val("post-reset underrun", obs_und[399], 0);
        check_val("post-reset fill_line", obs_line[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scanline_buffer.md
SCANLINE_BUFFER -- requirements
Module: scanline_buffer

Interface
REQ-001 SHALL have ports: clk_12_5875  input  1  pixel clock; all logic on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: hcounter_i, vcounter_i  input  10 each  raster position from the timing stage.
REQ-004 SHALL have: hsync_i, vsync_i  input  1 each  active-low syncs from the timing stage.
REQ-005 SHALL have: visible_i  input  1  raster inside 320x480 active area.
REQ-006 SHALL have: fill_line_o  output  9  display line (0..479) the pixel source must produce.
REQ-007 SHALL have: fill_valid_i  input  1, fill_color_i  input  6 ({r[1:0],g[1:0],b[1:0]}), fill_ready_o  output  1  pixel stream handshake.
REQ-008 SHALL have: r_o, g_o, b_o  output  2 each  pixel colour; hsync_o, vsync_o  output  1 each  delayed syncs.
REQ-009 SHALL have: underrun_o  output  1  sticky flag for a fill that did not complete in time.

Function
REQ-010 SHALL hold two line banks, each 320 x 6 bits; bank index = line number bit 0.
REQ-011 SHALL compute target = (vcounter_i == 524) ? 0 : vcounter_i + 1; a fill starts when hcounter_i == 0 and target < 480.
REQ-012 SHALL implement fill FSM states IDLE, FILL. IDLE -> FILL on fill start; FILL -> IDLE after the 320th accepted beat.
REQ-013 On fill start: fill_line_o <= target; write address <= 0; bank_valid[target[0]] <= 0.
REQ-014 fill_ready_o SHALL be 1 only in FILL; a beat is accepted when fill_valid_i && fill_ready_o, written to address 0,1,...,319 of bank target[0].
REQ-015 On the 320th accepted beat: bank_valid[target[0]] <= 1 and FSM -> IDLE in the same edge.
REQ-016 If a fill start occurs while in FILL: set underrun_o, leave the old bank invalid, restart the fill for the new target (address 0, new fill_line_o) on that edge.
REQ-017 underrun_o SHALL remain 1 until rst.
REQ-018 Display read: stage 1 registers read address hcounter_i[8:0], bank vcounter_i[0], gate = visible_i && bank_valid[vcounter_i[0]]; stage 2 registers RAM data.
REQ-019 Colour outputs SHALL equal the pixel at hcounter_i exactly 2 cycles after that hcounter_i is presented, else 0 when the gate was 0.
REQ-020 hsync_o, vsync_o SHALL be hsync_i, vsync_i delayed exactly 2 cycles, aligned with colour.
REQ-021 A write and a read to the same bank/address in one cycle cannot occur by construction (fill bank != display bank during visible lines); no bypass required.

Reset
REQ-022 On rst: FSM = IDLE, fill_ready_o = 0, fill_line_o = 0, bank_valid = 2'b00, underrun_o = 0, r_o/g_o/b_o = 0, hsync_o = vsync_o = 1, sync/gate pipelines = inactive.
REQ-023 Bank RAM contents SHALL NOT require reset; bank_valid gating guarantees black output from unfilled banks.
REQ-024 rst during FILL SHALL abandon the fill; no bank marked valid.

Verification
REQ-025 Reset then first frame line 0 -> r/g/b = 0 for all of line 0 (bank 0 invalid); fill_line_o = 1 after first hcounter 0.
REQ-026 Source always valid with colour = x[5:0] on line 5 -> fill completes 320 cycles after start; line 6 outputs colour 0..63 repeating, 2-cycle delayed vs hcounter.
REQ-027 Source withholds valid after 100 beats for line 10 -> at next line start underrun_o = 1, line 10 displayed black, fill restarts with fill_line_o = 11.
REQ-028 vcounter_i = 524, hcounter_i = 0 -> fill_line_o = 0, bank 0 filled; vcounter 479 -> no fill started (target 480).
REQ-029 Toggle hsync_i/vsync_i arbitrarily -> outputs match inputs delayed exactly 2 cycles; after rst both = 1.
REQ-030 Assert rst mid-fill at beat 150 -> fill_ready_o = 0 next cycle, bank_valid cleared, underrun_o = 0, outputs black.
